// File: rtl/md_unit.sv
// Multiply/divide unit: fixed-latency mult/div committing into architectural HI/LO.
// Optional build macro MDU_MADD_EN enables the madd/maddu/msub/msubu accumulate ops.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic        [3:0]  cnt;
    logic        [3:0]  op_q;
    logic        [31:0] a_q;
    logic        [31:0] b_q;
    logic               mul_req;
    logic               div_req;
    logic               commit_en;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] res;

    // Signed divide; the most-negative / -1 case wraps instead of trapping.
    function automatic logic [63:0] div_s(input logic signed [31:0] n,
                                          input logic signed [31:0] d);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (d == 32'sd0) begin
            q = 32'sd0;
            r = 32'sd0;
        end else if (n == {1'b1, 31'b0} && d == -32'sd1) begin
            q = n;
            r = 32'sd0;
        end else begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] div_u(input logic [31:0] n, input logic [31:0] d);
        if (d == 32'd0)
            return 64'd0;
        return {n % d, n / d};
    endfunction

`ifdef MDU_MADD_EN
    assign mul_req = (md_op == OP_MULT)  || (md_op == OP_MULTU) ||
                     (md_op == OP_MADD)  || (md_op == OP_MADDU) ||
                     (md_op == OP_MSUB)  || (md_op == OP_MSUBU);
`else
    assign mul_req = (md_op == OP_MULT) || (md_op == OP_MULTU);
`endif
    assign div_req = (md_op == OP_DIV) || (md_op == OP_DIVU);

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Division by zero leaves HI/LO untouched even though it still occupies the unit.
    assign commit_en = !(((op_q == OP_DIV) || (op_q == OP_DIVU)) && (b_q == 32'd0));

    always_comb begin
        res = {HI, LO};
        case (op_q)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = div_s(a_q, b_q);
            OP_DIVU:  res = div_u(a_q, b_q);
`ifdef MDU_MADD_EN
            OP_MADD:  res = {HI, LO} + prod_s;
            OP_MADDU: res = {HI, LO} + prod_u;
            OP_MSUB:  res = {HI, LO} - prod_s;
            OP_MSUBU: res = {HI, LO} - prod_u;
`endif
            default:  res = {HI, LO};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
            op_q  <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mul_req || div_req) begin
                            a_q   <= A;
                            b_q   <= B;
                            op_q  <= md_op;
                            cnt   <= mul_req ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                            busy  <= 1'b1;
                            state <= RUN;
                        end else if (md_op == OP_MTHI) begin
                            HI <= A;
                        end else if (md_op == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (commit_en) begin
                            HI <= res[63:32];
                            LO <= res[31:0];
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table plus scoreboard, then hand-written corner sequences.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t vt[12];
    exp_t sb[$];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after busy falls.
    task automatic run_op(input vec_t v, input string name);
        exp_t e;
        int   c;
        sb.push_back('{v.hi, v.lo});
        start = 1'b1;
        md_op = v.op;
        A     = v.a;
        B     = v.b;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (busy && c < 40) begin
            c++;
            @(negedge clk);
        end
        check({name, "_cycles"}, c, v.cyc);
        e = sb.pop_front();
        check({name, "_hi"}, HI, e.hi);
        check({name, "_lo"}, LO, e.lo);
    endtask

    task automatic pulse(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   c;
        logic seen_busy;

        vt[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vt[1]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vt[2]  = '{4'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vt[3]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vt[4]  = '{4'd0, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 5};
        vt[5]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[6]  = '{4'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vt[7]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vt[8]  = '{4'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vt[9]  = '{4'd3, 32'd7,        32'd0,        32'h00000002, 32'h0000000E, 10};
        vt[10] = '{4'd2, 32'hFFFFFFFB, 32'd0,        32'h00000002, 32'h0000000E, 10};
        vt[11] = '{4'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};

        reset = 1'b0;
        start = 1'b0;
        md_op = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back: each op starts in the first idle cycle after the previous one.
        for (int i = 0; i < 12; i++)
            run_op(vt[i], $sformatf("vec%0d", i));

        pulse(4'd4, 32'h12345678, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", HI, 32'h12345678);
        check("mthi_lo_kept", LO, 32'h0FFFFFFF);
        pulse(4'd5, 32'h9ABCDEF0, 32'd0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        check("mtlo_lo", LO, 32'h9ABCDEF0);
        check("mtlo_hi_kept", HI, 32'h12345678);

        pulse(4'd12, 32'h55555555, 32'h55555555);
        check("unused_busy", {31'd0, busy}, 32'd0);
        check("unused_hi", HI, 32'h12345678);

        // Starts arriving while a divide runs must be ignored, including MTHI.
        sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD});
        pulse(4'd2, 32'hFFFFFFF9, 32'd2);
        c = 0;
        while (busy && c < 40) begin
            c++;
            if (c == 3) begin
                start = 1'b1; md_op = 4'd0; A = 32'd1; B = 32'd1;
            end else if (c == 5) begin
                start = 1'b1; md_op = 4'd4; A = 32'hDEADBEEF; B = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_cycles", c, 32'd10);
        e = sb.pop_front();
        check("ign_hi", HI, e.hi);
        check("ign_lo", LO, e.lo);
        @(negedge clk);
        check("ign_no_rerun", {31'd0, busy}, 32'd0);

        // Reset mid-divide once the down-counter reaches 4.
        pulse(4'd3, 32'd100, 32'd7);
        repeat (6) @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_hi", HI, 32'd0);
        check("mid_rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen_busy = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        check("mid_no_busy", {31'd0, seen_busy}, 32'd0);
        check("mid_no_commit_hi", HI, 32'd0);
        check("mid_no_commit_lo", LO, 32'd0);

        pulse(4'd5, 32'd5, 32'd0);
        check("acc_init_lo", LO, 32'd5);
`ifdef MDU_MADD_EN
        run_op('{4'd6, 32'd2, 32'd3, 32'h00000000, 32'h0000000B, 5}, "madd");
        run_op('{4'd9, 32'd4, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFB, 5}, "msubu");
`else
        pulse(4'd6, 32'd2, 32'd3);
        check("madd_off_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("madd_off_lo", LO, 32'd5);
        pulse(4'd9, 32'd4, 32'd4);
        check("msubu_off_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("msubu_off_hi", HI, 32'd0);
        check("msubu_off_lo", LO, 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
